// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage core: operand forwarding, load-use and multi-cycle
// execute stalls, control-flow flushes and saturating stall/flush counters.
module hazard_ctrl_mc #(
    parameter int NSRC    = 3,
    parameter int RW      = 4,
    parameter int MUL_LAT = 3,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*RW-1:0]   SrcE,
    input  logic [NSRC-1:0]      SrcEValid,
    input  logic [NSRC*RW-1:0]   SrcD,
    input  logic [NSRC-1:0]      SrcDValid,
    input  logic [RW-1:0]        WA3E,
    input  logic                 MemtoRegE,
    input  logic                 MemWriteE,
    input  logic [RW-1:0]        WA3M,
    input  logic [RW-1:0]        WA3W,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [RW-1:0]        WBAM,
    input  logic [RW-1:0]        WBAW,
    input  logic                 WriteBackM,
    input  logic                 WriteBackW,
    input  logic                 MultiStartE,
    input  logic                 BranchTakenD,
    input  logic                 PCSrcW,
    input  logic                 PCWrPendingF,
    input  logic                 CntClr,
    output logic [NSRC*3-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic                 MulBusy,
    output logic [CNTW-1:0]      StallCount,
    output logic [CNTW-1:0]      FlushCount
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic       MULTI    = (MUL_LAT > 1);
    localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       mul_stall;
    logic       ms;
    logic       ldr_stall;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] val, input logic inc);
        if (inc && (val != {CNTW{1'b1}}))
            return val + 1'b1;
        return val;
    endfunction

    // Nearer stage wins; within a stage the result port beats base writeback.
    always_comb begin
        logic [RW-1:0] src;
        ForwardE = '0;
        for (int i = 0; i < NSRC; i++) begin
            src = SrcE[i*RW +: RW];
            if (SrcEValid[i]) begin
                if (RegWriteM && (src == WA3M))
                    ForwardE[i*3 +: 3] = 3'b010;
                else if (WriteBackM && (src == WBAM))
                    ForwardE[i*3 +: 3] = 3'b100;
                else if (RegWriteW && (src == WA3W))
                    ForwardE[i*3 +: 3] = 3'b001;
                else if (WriteBackW && (src == WBAW))
                    ForwardE[i*3 +: 3] = 3'b011;
            end
        end
    end

    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NSRC; i++)
            hit = hit | (SrcDValid[i] && (SrcD[i*RW +: RW] == WA3E));
        ldr_stall = MemtoRegE & ~MemWriteE & hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The final BUSY cycle ignores MultiStartE since it still belongs to the running op.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mul_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (MultiStartE && MULTI) begin
                    mul_stall  = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    mul_stall = 1'b1;
                    cnt_next  = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
        if (PCSrcW) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end
    end

    assign ms      = mul_stall & ~PCSrcW;
    assign MulBusy = (state == BUSY);
    assign StallE  = ms;
    assign StallD  = ms | ldr_stall;
    assign StallF  = StallD | PCWrPendingF;
    assign FlushM  = ms;
    assign FlushE  = PCSrcW | (ldr_stall & ~ms);
    assign FlushD  = PCSrcW | (~StallD & (PCWrPendingF | BranchTakenD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (CntClr) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            StallCount <= sat_inc(StallCount, StallD);
            FlushCount <= sat_inc(FlushCount, FlushD);
        end
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage core.
- Derives forwarding selects internally from register addresses for NSRC execute-stage operands, covering both result and base-writeback write ports in M and W.
- Adds load-use detection over NSRC decode operands and a multi-cycle execute FSM that holds E for MUL_LAT cycles.
- Provides saturating stall/flush performance counters. Sits beside the datapath and drives all pipeline-register enables and clears.

Parameters:
- NSRC, 3, number of source operands checked in D and E.
- RW, 4, register address width.
- MUL_LAT, 3, cycles a multi-cycle op occupies E (>=1).
- CNTW, 16, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- SrcE  in  NSRC*RW  E operand addresses, operand i at [i*RW+:RW]
- SrcEValid  in  NSRC  operand i actually read
- SrcD  in  NSRC*RW  D operand addresses
- SrcDValid  in  NSRC  D operand i actually read
- WA3E  in  RW  E destination address
- MemtoRegE, MemWriteE  in  1  E is load / store
- WA3M, WA3W  in  RW  M/W result destination addresses
- RegWriteM, RegWriteW  in  1  result write enables
- WBAM, WBAW  in  RW  M/W base-writeback addresses
- WriteBackM, WriteBackW  in  1  base-writeback enables
- MultiStartE  in  1  E holds a multi-cycle op
- BranchTakenD, PCSrcW, PCWrPendingF  in  1  control-flow events
- CntClr  in  1  synchronous counter clear
- ForwardE  out  NSRC*3  per-operand select
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  clear stage register
- MulBusy  out  1  FSM in BUSY
- StallCount, FlushCount  out  CNTW  performance counters

Behaviour:
- Forward code per operand i, considered only when SrcEValid[i]=1, first match wins:
  - 3'b010: WA3M match with RegWriteM
  - 3'b100: WBAM match with WriteBackM
  - 3'b001: WA3W match with RegWriteW
  - 3'b011: WBAW match with WriteBackW
  - else 3'b000 (register file)
- ForwardE is purely combinational.
- ldrStall = MemtoRegE & ~MemWriteE & OR over i of (SrcDValid[i] & SrcD[i]==WA3E).
- FSM states: IDLE, BUSY. The 4-bit counter cnt resets to 0.
- mulStall = (IDLE & MultiStartE & MUL_LAT>1) | (BUSY & cnt!=0).
  - IDLE with MultiStartE and MUL_LAT>1 -> BUSY, cnt<=MUL_LAT-2.
  - BUSY with cnt!=0: cnt decrements.
  - BUSY with cnt==0 -> IDLE. MultiStartE is ignored in that cycle because it is the same op.
  - MUL_LAT=1: never leaves IDLE.
- PCSrcW has highest priority. It masks mulStall combinationally and forces IDLE, cnt<=0 next cycle (aborts the op).
- Stall and flush equations, with ms = mulStall & ~PCSrcW:
  - StallE = ms
  - StallD = ms | ldrStall
  - StallF = StallD | PCWrPendingF
  - FlushM = ms (bubble into M)
  - FlushE = PCSrcW | (ldrStall & ~ms)
  - FlushD = PCSrcW | (~StallD & (PCWrPendingF | BranchTakenD))
- MulBusy = (state==BUSY).
- Counters:
  - StallCount +1 each cycle StallD=1; FlushCount +1 each cycle FlushD=1.
  - Both saturate at all-ones.
  - CntClr zeroes them and takes priority over increment.
- Reset (reset=0, asynchronous): state IDLE, cnt 0, counters 0.
  - The combinational outputs then depend only on their inputs.
  - Reset mid-BUSY drops the stall immediately.

Test Plan:
- Forward priority: SrcE operand0 = 5, WA3M = 5, RegWriteM = 1, WBAW = 5, WriteBackW = 1 -> ForwardE[2:0] = 010. Drop RegWriteM -> 011. SrcEValid[0] = 0 -> 000.
- Index port: operand2 = 7, WBAM = 7, WriteBackM = 1, WA3W = 7, RegWriteW = 1 -> ForwardE[8:6] = 100.
- Load-use: MemtoRegE = 1, MemWriteE = 0, WA3E = 3, SrcD operand1 = 3, valid -> StallF = StallD = FlushE = 1, FlushD = 0. With MemWriteE = 1 -> all 0.
- MUL_LAT = 3, MultiStartE held 3 cycles -> StallE = StallD = StallF = FlushM = 1 for cycles 0 and 1, 0 in cycle 2; MulBusy = 1 in cycles 1–2; IDLE in cycle 3.
- Abort: PCSrcW = 1 in BUSY cycle 1 -> stalls 0 that cycle, FlushD = FlushE = 1, MulBusy = 0 next cycle. Reset asserted mid-BUSY -> MulBusy = 0 immediately.
- Counters, CNTW = 2: StallD high for 5 cycles -> StallCount 1, 2, 3, 3, 3. CntClr together with StallD -> 0.
